// File: rtl/plic_target_agent.sv
// PLIC target agent: claims the highest-priority pending interrupt, dispatches it
// to a handler, completes it, then holds off while the PLIC's registered ireq/id settle.
module plic_target_agent #(
  parameter int unsigned SOURCES      = 8,
  parameter int unsigned SOURCES_BITS = $clog2(SOURCES + 1),
  parameter int unsigned TIMEOUT      = 0,
  parameter int unsigned HOLDOFF      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ireq,
  input  logic [SOURCES_BITS-1:0] id,
  output logic                    claim,
  output logic                    complete,
  output logic                    hnd_valid,
  output logic [SOURCES_BITS-1:0] hnd_id,
  input  logic                    hnd_ready,
  input  logic                    hnd_done,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr,
  output logic [7:0]              spurious_cnt
);

  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned HO_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam int unsigned HO_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_CLAIM, S_DISPATCH, S_SERVICE, S_COMPLETE, S_HOLDOFF
  } state_t;

  state_t                  state, state_next;
  logic [SOURCES_BITS-1:0] cap_id;
  logic [WD_W-1:0]         wd_cnt;
  logic [HO_W-1:0]         ho_cnt;
  logic                    wd_hit, ho_last, timeout_hit;
  logic                    claim_d, complete_d, hnd_valid_d, busy_d;
  logic [SOURCES_BITS-1:0] hnd_id_d;

  assign wd_hit  = (TIMEOUT != 0) && (wd_cnt == WD_W'(WD_LAST));
  assign ho_last = (ho_cnt == HO_W'(HO_LAST));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a normal handler transition beats the watchdog
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:     if (en && ireq && (id != '0)) state_next = S_CLAIM;
      S_CLAIM:    if (id == '0) state_next = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                  else          state_next = S_DISPATCH;
      S_DISPATCH: begin
        if (hnd_ready && hnd_done) state_next = S_COMPLETE;
        else if (hnd_ready)        state_next = S_SERVICE;
        else if (wd_hit) begin
          state_next  = S_COMPLETE;
          timeout_hit = 1'b1;
        end
      end
      S_SERVICE: begin
        if (hnd_done) state_next = S_COMPLETE;
        else if (wd_hit) begin
          state_next  = S_COMPLETE;
          timeout_hit = 1'b1;
        end
      end
      S_COMPLETE: state_next = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
      S_HOLDOFF:  if (ho_last) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    claim_d     = (state_next == S_CLAIM);
    complete_d  = (state_next == S_COMPLETE);
    hnd_valid_d = (state_next == S_DISPATCH);
    busy_d      = (state_next != S_IDLE);
    hnd_id_d    = '0;
    if (state_next == S_DISPATCH || state_next == S_SERVICE || state_next == S_COMPLETE)
      hnd_id_d = (state == S_CLAIM) ? id : cap_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      claim        <= 1'b0;
      complete     <= 1'b0;
      hnd_valid    <= 1'b0;
      hnd_id       <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_cnt <= 8'd0;
      cap_id       <= '0;
      wd_cnt       <= '0;
      ho_cnt       <= '0;
    end else begin
      claim     <= claim_d;
      complete  <= complete_d;
      hnd_valid <= hnd_valid_d;
      hnd_id    <= hnd_id_d;
      busy      <= busy_d;
      if (state == S_CLAIM) cap_id <= id;
      if (state == S_CLAIM && id == '0 && spurious_cnt != 8'hFF)
        spurious_cnt <= spurious_cnt + 8'd1;
      // Watchdog saturates at its last count so a late DISPATCH->SERVICE still trips it
      if (state == S_CLAIM)
        wd_cnt <= '0;
      else if ((state == S_DISPATCH || state == S_SERVICE) && !wd_hit && TIMEOUT != 0)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (state != S_HOLDOFF)
        ho_cnt <= '0;
      else
        ho_cnt <= ho_cnt + HO_W'(1);
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule
